// File: rtl/dmem_wait_ctrl.sv
// Data memory with configurable access latency, stall handshake to the pipeline,
// byte/half/word lane-masked stores, sign/zero-extended loads and misalignment flagging.
module dmem_wait_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = AW + 2;
    localparam int unsigned CW = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;

    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [BW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          access_c;
    logic          misalign_c;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   rd_sh;
    logic [31:0]   load_ext;
    logic [3:0]    wmask;
    logic [31:0]   wdata_sh;
    logic          unused_addr;

    // Address bits above the array size are ignored so accesses wrap.
    assign unused_addr = ^addr_i[31:BW];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign access_c = (state == BUSY) && (cnt == '0);
    assign idx      = addr_q[BW-1:2];

    // Stall while a request is being accepted or is in flight; released by reset.
    assign stall_o = ~reset & (((state == IDLE) & req_i) | (state == BUSY));

    // Request capture and latency countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if ((state == IDLE) && req_i) begin
            cnt     <= CW'(LATENCY - 1);
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i[BW-1:0];
            wdata_q <= wdata_i;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Alignment check on the latched request.
    always_comb begin
        misalign_c = 1'b0;
        case (size_q)
            2'b01:   misalign_c = addr_q[0];
            2'b10:   misalign_c = (addr_q[1:0] != 2'b00);
            2'b11:   misalign_c = 1'b1;
            default: misalign_c = 1'b0;
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        rd_word  = mem[idx];
        rd_sh    = rd_word >> {addr_q[1:0], 3'b000};
        load_ext = rd_word;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h000000, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0000, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    // Store lane mask and data alignment.
    always_comb begin
        wdata_sh = wdata_q << {addr_q[1:0], 3'b000};
        wmask    = 4'b1111;
        case (size_q)
            2'b00:   wmask = 4'b0001 << addr_q[1:0];
            2'b01:   wmask = 4'b0011 << {addr_q[1], 1'b0};
            default: wmask = 4'b1111;
        endcase
    end

    // Completion outputs; rdata holds until the next access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_o    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            done_o     <= access_c;
            misalign_o <= access_c & misalign_c;
            if (access_c) rdata_o <= (we_q | misalign_c) ? 32'h0 : load_ext;
        end
    end

    // Memory write at the completing edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (access_c && we_q && !misalign_c) begin
            for (int l = 0; l < 4; l++) begin
                if (wmask[l]) mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
            end
        end
    end

endmodule
